matmul_scheduler: RTL and testbench
===================================

Name: matmul_scheduler

Overview:
- Sequences a complete N x N single-precision floating-point matrix product C = A x B through one shared inner_product engine.
- Accepts both operand matrices with a strobe/ack handshake and latches them.
- Issues the N*N row/column pairs to the engine one at a time, in row-major order, and collects each scalar result into an output matrix register.
- Presents C with a strobe/ack handshake. Sits between the top-level matrix interface and the inner_product instance.

Parameters:
- N, 4, matrix dimension; also the engine's number_of_elements.
- WORD, 32, element width (IEEE-754 single), fixed at 32.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous active-low reset.
- a_in  in  WORD*N*N  matrix A; element (r,c) at bits [WORD*(r*N+c) +: WORD].
- a_in_stb  in  1  A valid.
- a_in_ack  out  1  A accepted.
- b_in  in  WORD*N*N  matrix B, same packing as A.
- b_in_stb  in  1  B valid.
- b_in_ack  out  1  B accepted.
- c_out  out  WORD*N*N  result matrix C, same packing as A.
- c_out_stb  out  1  C valid.
- c_out_ack  in  1  C consumed.
- busy  out  1  high in every state except IDLE.
- ip_row  out  WORD*N  to engine: row r of A; word k = A(r,k).
- ip_row_stb  out  1  to engine.
- ip_row_ack  in  1  from engine.
- ip_column  out  WORD*N  to engine: column c of B; word k = B(k,c).
- ip_column_stb  out  1  to engine.
- ip_column_ack  in  1  from engine.
- ip_out  in  WORD  engine result.
- ip_out_stb  in  1  engine result valid.
- ip_out_ack  out  1  result consumed.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; r and c counters go to 0.
  - All strobe, ack and busy outputs go to 0.
  - c_out, the latched A/B registers, ip_row and ip_column go to all zeros.
  - Reset mid-operation abandons the product. No partial C is presented.
- IDLE:
  - When a_in_stb & b_in_stb are both high, latch a_in and b_in, pulse a_in_ack and b_in_ack high for exactly one cycle, clear r and c, and go to ISSUE.
  - One strobe alone is ignored and no ack is given.
- ISSUE:
  - Drive ip_row and ip_column from the latched matrices at the current (r,c), registered.
  - Hold ip_row_stb and ip_column_stb high.
  - Each stb drops independently on the cycle after its own ack is seen.
  - Once both acks have been seen, in the same cycle or in different cycles, go to WAIT_RES.
- WAIT_RES:
  - On ip_out_stb=1, write ip_out into C(r,c), raise ip_out_ack, and go to RELEASE.
- RELEASE:
  - Hold ip_out_ack high until ip_out_stb is sampled low, then drop ip_out_ack. This guarantees the engine has returned to its idle state.
  - Advance: c=c+1. When c wraps from N-1 to 0, r=r+1.
  - If (r,c) was (N-1,N-1), go to DONE; otherwise go to ISSUE.
- DONE:
  - c_out_stb is high with c_out stable. Hold until c_out_ack=1.
  - Next cycle: c_out_stb=0 and go to IDLE. c_out keeps its value until the next result write.
- Operands:
  - A and B are latched once per product. Changes on a_in/b_in after the ack have no effect.
  - New a_in_stb/b_in_stb while busy are not acked.
- Ordering: results are written in row-major order: C(0,0), C(0,1), ..., C(N-1,N-1).
- Minimum latency, with an engine that acks immediately and returns its result after L cycles:
  - Per element: about L+4 cycles.
  - A/B ack to c_out_stb: N*N*(L+4)+1 cycles.
- No arithmetic is done in this block. All floating-point work is done by the engine.
- Boundary cases:
  - The engine asserting ip_out_stb during ISSUE is a protocol error. Ignore it until WAIT_RES.
  - c_out_ack while not in DONE is ignored.
  - c_out_ack and a new a_in_stb/b_in_stb in the same cycle: the ack is taken in DONE; the new operands are accepted in IDLE on a later cycle.

Test Plan:
- N=2. A=identity (0x3F800000 on the diagonal, 0 elsewhere), B=[1.0,2.0;3.0,4.0] -> c_out = B (0x3F800000, 0x40000000, 0x40400000, 0x40800000). c_out_stb stays high until c_out_ack.
- N=2. Stub engine records each (ip_row, ip_column) pair; A=[1,2;3,4], B=[5,6;7,8] -> pairs are issued in order (r0,c0), (r0,c1), (r1,c0), (r1,c1). ip_column for c=1 = {8.0, 6.0} packed with word0=6.0 (0x40C00000).
- Split acks: stub acks the row 3 cycles before the column -> ip_row_stb drops first, ip_column_stb stays high until its ack, and exactly one result is captured per pair.
- Only a_in_stb high for 10 cycles -> no a_in_ack, busy=0. Then b_in_stb rises -> both acks pulse in the same cycle, one cycle wide.
- Assert rst low during WAIT_RES of element (1,0) -> all outputs read 0 while reset is held. After release, a full new product completes correctly.
- N=4 with the real inner_product engine: A=B=all 1.0 -> every C element = 4.0 (0x40800000). Verify busy falls the cycle after the c_out_ack handshake.

Source files
------------

// File: rtl/matmul_scheduler_if.sv
// ---------------------------------------------------------------------------
// matmul_scheduler_if
//
// Purpose: bundles every handshake/data signal of matmul_scheduler, both the
// matrix-side port (A, B in; C out) and the inner_product engine port.
//
// Modports:
//   slave  - the scheduler itself: receives A/B and engine results, drives C,
//            busy and the row/column operands to the engine.
//   master - the environment: the matrix producer/consumer plus the engine.
//
// Signal summary (N = matrix dimension, WORD = element width):
//   a_in/b_in      [WORD*N*N]  operand matrices, element (r,c) at WORD*(r*N+c)
//   a_in_stb/ack, b_in_stb/ack operand handshakes
//   c_out          [WORD*N*N]  result matrix, same packing
//   c_out_stb/ack              result handshake
//   busy                       scheduler not idle
//   ip_row/ip_column [WORD*N]  engine operands (row r of A, column c of B)
//   ip_row_stb/ack, ip_column_stb/ack, ip_out[WORD], ip_out_stb/ack
// ---------------------------------------------------------------------------
interface matmul_scheduler_if #(
    parameter int N    = 4,
    parameter int WORD = 32
);
    logic [WORD*N*N-1:0] a_in;
    logic                a_in_stb;
    logic                a_in_ack;
    logic [WORD*N*N-1:0] b_in;
    logic                b_in_stb;
    logic                b_in_ack;
    logic [WORD*N*N-1:0] c_out;
    logic                c_out_stb;
    logic                c_out_ack;
    logic                busy;
    logic [WORD*N-1:0]   ip_row;
    logic                ip_row_stb;
    logic                ip_row_ack;
    logic [WORD*N-1:0]   ip_column;
    logic                ip_column_stb;
    logic                ip_column_ack;
    logic [WORD-1:0]     ip_out;
    logic                ip_out_stb;
    logic                ip_out_ack;

    modport slave (
        input  a_in, a_in_stb, b_in, b_in_stb, c_out_ack,
        input  ip_row_ack, ip_column_ack, ip_out, ip_out_stb,
        output a_in_ack, b_in_ack, c_out, c_out_stb, busy,
        output ip_row, ip_row_stb, ip_column, ip_column_stb, ip_out_ack
    );

    modport master (
        output a_in, a_in_stb, b_in, b_in_stb, c_out_ack,
        output ip_row_ack, ip_column_ack, ip_out, ip_out_stb,
        input  a_in_ack, b_in_ack, c_out, c_out_stb, busy,
        input  ip_row, ip_row_stb, ip_column, ip_column_stb, ip_out_ack
    );
endinterface

// File: rtl/matmul_scheduler.sv
// ---------------------------------------------------------------------------
// matmul_scheduler
//
// Purpose: sequences an N x N single-precision matrix product C = A x B
// through one shared inner_product engine. Both operands are latched with a
// single strobe/ack handshake, then the N*N row/column pairs are issued in
// row-major order; each scalar result is written into the C register and the
// finished matrix is offered with a strobe/ack handshake. No arithmetic is
// performed here.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - matmul_scheduler_if.slave (matrix port + engine port + busy)
//
// State flow: IDLE -> ISSUE -> WAIT_RES -> RELEASE -> (ISSUE | DONE) -> IDLE
// ---------------------------------------------------------------------------
module matmul_scheduler #(
    parameter int N    = 4,
    parameter int WORD = 32
) (
    input  logic               clk,
    input  logic               rst,
    matmul_scheduler_if.slave  bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = WORD * N * N;
    localparam int RW = WORD * N;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        RELEASE,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   r;
    logic [CW-1:0]   c;
    logic [MW-1:0]   a_reg;
    logic [MW-1:0]   b_reg;
    logic [MW-1:0]   c_reg;
    logic [RW-1:0]   row_reg;
    logic [RW-1:0]   col_reg;
    logic            row_stb;
    logic            col_stb;
    logic            out_ack;
    logic            a_ack;
    logic            b_ack;
    logic            c_stb;
    logic            busy_reg;

    logic [CW-1:0]   next_r;
    logic [CW-1:0]   next_c;
    logic            last_elem;
    logic            row_done;
    logic            col_done;

    // Row ri of a packed matrix: words are already contiguous.
    function automatic logic [RW-1:0] row_of(input logic [MW-1:0] m,
                                             input logic [CW-1:0] ri);
        return m[RW*int'(ri) +: RW];
    endfunction

    // Column ci of a packed matrix: word k of the result is element (k,ci).
    function automatic logic [RW-1:0] col_of(input logic [MW-1:0] m,
                                             input logic [CW-1:0] ci);
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[WORD*k +: WORD] = m[WORD*(k*N + int'(ci)) +: WORD];
        end
        return v;
    endfunction

    // Row-major advance of the (r,c) cursor.
    always_comb begin
        next_c    = (c == CW'(N-1)) ? '0 : c + CW'(1);
        next_r    = (c == CW'(N-1)) ? r + CW'(1) : r;
        last_elem = (c == CW'(N-1)) && (r == CW'(N-1));
    end

    // A strobe counts as handshaken once it has been dropped or its ack is
    // present now; this lets the two acks arrive in any order.
    assign row_done = !row_stb || bus.ip_row_ack;
    assign col_done = !col_stb || bus.ip_column_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            r        <= '0;
            c        <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= '0;
            row_reg  <= '0;
            col_reg  <= '0;
            row_stb  <= 1'b0;
            col_stb  <= 1'b0;
            out_ack  <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            c_stb    <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            // Operand acks are single-cycle pulses.
            a_ack <= 1'b0;
            b_ack <= 1'b0;

            case (state)
                IDLE: begin
                    // Both operands must be offered together; a lone strobe waits.
                    if (bus.a_in_stb && bus.b_in_stb) begin
                        a_reg    <= bus.a_in;
                        b_reg    <= bus.b_in;
                        a_ack    <= 1'b1;
                        b_ack    <= 1'b1;
                        r        <= '0;
                        c        <= '0;
                        // First pair comes straight from the inputs so the
                        // engine operands are valid on the first ISSUE cycle.
                        row_reg  <= row_of(bus.a_in, '0);
                        col_reg  <= col_of(bus.b_in, '0);
                        row_stb  <= 1'b1;
                        col_stb  <= 1'b1;
                        busy_reg <= 1'b1;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (row_stb && bus.ip_row_ack) begin
                        row_stb <= 1'b0;
                    end
                    if (col_stb && bus.ip_column_ack) begin
                        col_stb <= 1'b0;
                    end
                    if (row_done && col_done) begin
                        row_stb <= 1'b0;
                        col_stb <= 1'b0;
                        state   <= WAIT_RES;
                    end
                end

                WAIT_RES: begin
                    // A result strobe seen earlier, during ISSUE, is ignored.
                    if (bus.ip_out_stb) begin
                        c_reg[WORD*(int'(r)*N + int'(c)) +: WORD] <= bus.ip_out;
                        out_ack <= 1'b1;
                        state   <= RELEASE;
                    end
                end

                RELEASE: begin
                    // Hold the ack until the engine withdraws its strobe so it
                    // is back in idle before the next pair is offered.
                    if (!bus.ip_out_stb) begin
                        out_ack <= 1'b0;
                        r       <= next_r;
                        c       <= next_c;
                        if (last_elem) begin
                            c_stb <= 1'b1;
                            state <= DONE;
                        end else begin
                            row_reg <= row_of(a_reg, next_r);
                            col_reg <= col_of(b_reg, next_c);
                            row_stb <= 1'b1;
                            col_stb <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end

                DONE: begin
                    if (bus.c_out_ack) begin
                        c_stb    <= 1'b0;
                        busy_reg <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_in_ack      = a_ack;
    assign bus.b_in_ack      = b_ack;
    assign bus.c_out         = c_reg;
    assign bus.c_out_stb     = c_stb;
    assign bus.busy          = busy_reg;
    assign bus.ip_row        = row_reg;
    assign bus.ip_row_stb    = row_stb;
    assign bus.ip_column     = col_reg;
    assign bus.ip_column_stb = col_stb;
    assign bus.ip_out_ack    = out_ack;

endmodule

// File: tb/tb_matmul_scheduler.sv
// ---------------------------------------------------------------------------
// tb_matmul_scheduler
//
// Directed bench for matmul_scheduler. Two instances: N=2 with a configurable
// stub engine (ack delays, result latency, pair log) and N=4 with a simple
// immediate-ack engine. Engines compute small-integer dot products exactly.
// ---------------------------------------------------------------------------
module tb_matmul_scheduler;

    localparam logic [31:0] F0  = 32'h00000000;
    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F7  = 32'h40E00000;
    localparam logic [31:0] F8  = 32'h41000000;
    localparam logic [31:0] F19 = 32'h41980000;
    localparam logic [31:0] F22 = 32'h41B00000;
    localparam logic [31:0] F43 = 32'h422C0000;
    localparam logic [31:0] F50 = 32'h42480000;

    // Packing {e11, e10, e01, e00}
    localparam logic [127:0] M_ID   = {F1, F0, F0, F1};
    localparam logic [127:0] M_1234 = {F4, F3, F2, F1};
    localparam logic [127:0] M_5678 = {F8, F7, F6, F5};
    localparam logic [127:0] M_PROD = {F50, F43, F22, F19};

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    matmul_scheduler_if #(.N(2), .WORD(32)) bus2 ();
    matmul_scheduler_if #(.N(4), .WORD(32)) bus4 ();

    matmul_scheduler #(.N(2), .WORD(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    matmul_scheduler #(.N(4), .WORD(32)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Positive small-integer float <-> int helpers for the stub engines.
    function automatic int f2i(input logic [31:0] f);
        int          e;
        logic [23:0] m;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = {1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] i2f(input int v);
        int          p;
        logic [31:0] u;
        logic [31:0] sh;
        if (v == 0) return 32'd0;
        u = v;
        p = 0;
        for (int i = 0; i < 32; i++) if (u[i]) p = i;
        sh = u << (23 - p);
        return {1'b0, 8'(p + 127), sh[22:0]};
    endfunction

    function automatic int dotn(input logic [127:0] rw, input logic [127:0] cw, input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += f2i(rw[32*k +: 32]) * f2i(cw[32*k +: 32]);
        return s;
    endfunction

    // ---------------- N=2 stub engine ----------------
    int          row_dly = 0;
    int          col_dly = 0;
    int          lat2    = 1;
    int          pair_cnt  = 0;
    int          split_cnt = 0;
    logic [63:0] row_log [64];
    logic [63:0] col_log [64];
    int          st2, rc2, cc2, lc2;
    logic        rg2, cg2;
    logic [31:0] res2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            st2 <= 0; rc2 <= 0; cc2 <= 0; lc2 <= 0; rg2 <= 1'b0; cg2 <= 1'b0;
            res2 <= '0;
            bus2.ip_row_ack    <= 1'b0;
            bus2.ip_column_ack <= 1'b0;
            bus2.ip_out_stb    <= 1'b0;
            bus2.ip_out        <= '0;
        end else begin
            case (st2)
                0: if (bus2.ip_row_stb && bus2.ip_column_stb) begin
                    row_log[pair_cnt % 64] <= bus2.ip_row;
                    col_log[pair_cnt % 64] <= bus2.ip_column;
                    pair_cnt <= pair_cnt + 1;
                    res2 <= i2f(dotn({64'd0, bus2.ip_row}, {64'd0, bus2.ip_column}, 2));
                    rc2 <= 0; cc2 <= 0; rg2 <= 1'b0; cg2 <= 1'b0;
                    st2 <= 1;
                end
                1: begin
                    bus2.ip_row_ack    <= 1'b0;
                    bus2.ip_column_ack <= 1'b0;
                    if (!rg2) begin
                        if (rc2 >= row_dly) begin bus2.ip_row_ack <= 1'b1; rg2 <= 1'b1; end
                        else rc2 <= rc2 + 1;
                    end
                    if (!cg2) begin
                        if (cc2 >= col_dly) begin bus2.ip_column_ack <= 1'b1; cg2 <= 1'b1; end
                        else cc2 <= cc2 + 1;
                    end
                    if (!bus2.ip_row_stb && bus2.ip_column_stb) split_cnt <= split_cnt + 1;
                    if (rg2 && cg2) begin lc2 <= 0; st2 <= 2; end
                end
                2: if (lc2 >= lat2) begin
                    bus2.ip_out     <= res2;
                    bus2.ip_out_stb <= 1'b1;
                    st2 <= 3;
                end else lc2 <= lc2 + 1;
                default: if (bus2.ip_out_ack) begin
                    bus2.ip_out_stb <= 1'b0;
                    st2 <= 0;
                end
            endcase
        end
    end

    // ---------------- N=4 stub engine ----------------
    int          st4, lc4;
    logic [31:0] res4;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            st4 <= 0; lc4 <= 0; res4 <= '0;
            bus4.ip_row_ack    <= 1'b0;
            bus4.ip_column_ack <= 1'b0;
            bus4.ip_out_stb    <= 1'b0;
            bus4.ip_out        <= '0;
        end else begin
            case (st4)
                0: if (bus4.ip_row_stb && bus4.ip_column_stb) begin
                    bus4.ip_row_ack    <= 1'b1;
                    bus4.ip_column_ack <= 1'b1;
                    res4 <= i2f(dotn(bus4.ip_row, bus4.ip_column, 4));
                    st4  <= 1;
                end
                1: begin
                    bus4.ip_row_ack    <= 1'b0;
                    bus4.ip_column_ack <= 1'b0;
                    lc4 <= 0;
                    st4 <= 2;
                end
                2: if (lc4 >= 2) begin
                    bus4.ip_out     <= res4;
                    bus4.ip_out_stb <= 1'b1;
                    st4 <= 3;
                end else lc4 <= lc4 + 1;
                default: if (bus4.ip_out_ack) begin
                    bus4.ip_out_stb <= 1'b0;
                    st4 <= 0;
                end
            endcase
        end
    end

    // Offer A and B to the N=2 instance; optionally A alone for 10 cycles first.
    task automatic start2(input logic [127:0] a, input logic [127:0] b, input bit a_first);
        logic bad;
        bus2.a_in = a;
        bus2.b_in = b;
        if (a_first) begin
            bus2.a_in_stb = 1'b1;
            bad = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (bus2.a_in_ack !== 1'b0 || bus2.b_in_ack !== 1'b0 || bus2.busy !== 1'b0) bad = 1'b1;
            end
            check("solo_a_no_ack", bad, 1'b0);
        end
        bus2.a_in_stb = 1'b1;
        bus2.b_in_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus2.a_in_ack || bus2.b_in_ack) break;
        end
        check("ack_pair", {bus2.a_in_ack, bus2.b_in_ack}, 2'b11);
        bus2.a_in_stb = 1'b0;
        bus2.b_in_stb = 1'b0;
        bus2.a_in     = ~a;
        bus2.b_in     = ~b;
        bus2.c_out_ack = 1'b1;
        @(negedge clk);
        bus2.c_out_ack = 1'b0;
        check("ack_width", {bus2.a_in_ack, bus2.b_in_ack}, 2'b00);
        check("busy_run", bus2.busy, 1'b1);
    endtask

    // Wait for C on the N=2 instance, check it, hold off, then consume it.
    task automatic finish2(input logic [127:0] exp, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (bus2.c_out_stb) break;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, bus2.c_out_stb, 1'b1);
        check({tag, "_c"}, bus2.c_out, exp);
        repeat (3) @(negedge clk);
        check({tag, "_stb_hold"}, bus2.c_out_stb, 1'b1);
        check({tag, "_c_stable"}, bus2.c_out, exp);
        bus2.c_out_ack = 1'b1;
        @(negedge clk);
        bus2.c_out_ack = 1'b0;
        check({tag, "_stb_off"}, bus2.c_out_stb, 1'b0);
        check({tag, "_busy_off"}, bus2.busy, 1'b0);
        @(negedge clk);
        check({tag, "_c_kept"}, bus2.c_out, exp);
    endtask

    initial begin : stim
        int base;
        int sbase;
        bus2.a_in = '0; bus2.b_in = '0; bus2.a_in_stb = 1'b0; bus2.b_in_stb = 1'b0; bus2.c_out_ack = 1'b0;
        bus4.a_in = '0; bus4.b_in = '0; bus4.a_in_stb = 1'b0; bus4.b_in_stb = 1'b0; bus4.c_out_ack = 1'b0;

        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl2", {bus2.a_in_ack, bus2.b_in_ack, bus2.c_out_stb, bus2.busy,
                            bus2.ip_row_stb, bus2.ip_column_stb, bus2.ip_out_ack}, 7'd0);
        check("rst_c_out2", bus2.c_out, '0);
        check("rst_ip_ops2", {bus2.ip_row, bus2.ip_column}, '0);
        check("rst_busy4", {bus4.busy, bus4.c_out_stb}, 2'b00);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // Identity times B gives B
        start2(M_ID, M_1234, 1'b0);
        finish2(M_1234, "ident");

        // Lone A strobe, then B; pair order and column packing
        base = pair_cnt;
        start2(M_1234, M_5678, 1'b1);
        finish2(M_PROD, "prod");
        check("pair_count", pair_cnt - base, 4);
        check("pair0_row", row_log[(base + 0) % 64], {F2, F1});
        check("pair0_col", col_log[(base + 0) % 64], {F7, F5});
        check("pair1_col", col_log[(base + 1) % 64], {F8, F6});
        check("pair2_row", row_log[(base + 2) % 64], {F4, F3});
        check("pair2_col", col_log[(base + 2) % 64], {F7, F5});
        check("pair3_row", row_log[(base + 3) % 64], {F4, F3});
        check("pair3_col", col_log[(base + 3) % 64], {F8, F6});

        // Row acked 3 cycles before column
        col_dly = 3;
        base  = pair_cnt;
        sbase = split_cnt;
        start2(M_1234, M_ID, 1'b0);
        finish2(M_1234, "split");
        check("split_pairs", pair_cnt - base, 4);
        check("split_cycles", split_cnt - sbase, 12);
        col_dly = 0;

        // Reset while waiting for the result of element (1,0)
        lat2 = 6;
        base = pair_cnt;
        start2(M_1234, M_5678, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if ((pair_cnt - base) == 3 && st2 == 2) break;
            @(negedge clk);
        end
        check("rst_mid_reached", ((pair_cnt - base) == 3 && st2 == 2), 1'b1);
        rst = 1'b0;
        #1;
        check("rst_mid_ctrl", {bus2.a_in_ack, bus2.b_in_ack, bus2.c_out_stb, bus2.busy,
                               bus2.ip_row_stb, bus2.ip_column_stb, bus2.ip_out_ack}, 7'd0);
        check("rst_mid_data", {bus2.c_out, bus2.ip_row, bus2.ip_column}, '0);
        repeat (2) @(negedge clk);
        check("rst_mid_held", {bus2.busy, bus2.c_out_stb, bus2.c_out}, '0);
        rst  = 1'b1;
        lat2 = 1;
        @(negedge clk);
        check("rst_mid_idle", bus2.busy, 1'b0);
        start2(M_1234, M_5678, 1'b0);
        finish2(M_PROD, "after_rst");

        // N=4, all-ones operands
        bus4.a_in = {16{F1}};
        bus4.b_in = {16{F1}};
        bus4.a_in_stb = 1'b1;
        bus4.b_in_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus4.a_in_ack) break;
        end
        check("n4_ack", {bus4.a_in_ack, bus4.b_in_ack}, 2'b11);
        bus4.a_in_stb = 1'b0;
        bus4.b_in_stb = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus4.c_out_stb) break;
            @(negedge clk);
        end
        check("n4_done_seen", bus4.c_out_stb, 1'b1);
        check("n4_c", bus4.c_out, {16{F4}});
        check("n4_busy_before", bus4.busy, 1'b1);
        bus4.c_out_ack = 1'b1;
        @(negedge clk);
        bus4.c_out_ack = 1'b0;
        check("n4_busy_after", {bus4.busy, bus4.c_out_stb}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
